pb_bcd_counter: RTL and testbench
=================================

# pb_bcd_counter

Debounced push-button event counter producing three BCD digits (000–999) directly. It sits between the divided clock / push-button input and the three 7-segment display renderers, and supplies their `units`/`tens`/`hundreds` digits. It replaces free-running binary counting plus `%`/`/` conversion with a debounced, edge-counted BCD counter. An optional auto-repeat mode is included.

## Interface
Parameters:
- `DEB_CYCLES`, 4: consecutive stable synchronized samples required to accept a press or a release. Must be ≥1.
- `REPEAT_DELAY`, 16: cycles in HELD before the first auto-repeat increment. Must be ≥1.
- `REPEAT_PERIOD`, 4: cycles between auto-repeat increments. Must be ≥1.

Ports:
- `clkdiv0`  in  1  block clock (divided clock)
- `RST`  in  1  reset; RST, asynchronous, active-high; clock clkdiv0
- `pbton`  in  1  active-high push button, asynchronous to `clkdiv0`
- `clr`  in  1  synchronous clear of the digits
- `units`  out  4  BCD units digit
- `tens`  out  4  BCD tens digit
- `hundreds`  out  4  BCD hundreds digit
- `wrap`  out  1  one-cycle pulse on the 999→000 rollover
- `pressed`  out  1  debounced button state

## Operation
- `pbton` passes through a 2-flop synchronizer. Its output is `pb_s`. Both flops reset to 0.
- FSM states and transitions:
  - IDLE: `pb_s`=1 goes to DEB_PRESS with the debounce count set to 1. If `DEB_CYCLES`=1, it increments and goes straight to HELD instead.
  - DEB_PRESS: `pb_s`=0 returns to IDLE, with no increment. When the DEB_CYCLES-th consecutive high sample arrives, it issues one increment and goes to HELD.
  - HELD: `pb_s`=0 goes to DEB_REL. With auto-repeat enabled, on the REPEAT_DELAY-th cycle in HELD it issues an increment and goes to REPEAT.
  - REPEAT: issues an increment every REPEAT_PERIOD cycles. `pb_s`=0 goes to DEB_REL.
  - DEB_REL: `pb_s`=1 returns to HELD with the hold timer cleared and no increment. After DEB_CYCLES consecutive low samples (the entry sample counts as the first), it goes to IDLE.
- `pressed` is 1 in HELD, REPEAT and DEB_REL, and 0 otherwise. It is registered.
- Increment is a BCD ripple:
  - A digit at 9 becomes 0 and carries into the next digit.
  - 999 becomes 000 and `wrap`=1 for that same cycle.
  - No digit ever holds a value of 10–15.
- `clr` has priority over an increment in the same cycle: digits go to 000 and `wrap` stays 0. `clr` does not affect the FSM.
- Reset mid-operation: all state returns to its reset value immediately. A button still held at reset release needs a fresh debounce and produces exactly one increment.

## Timing
- Reset values:
  - `units`/`tens`/`hundreds` = 0
  - `wrap` = 0
  - `pressed` = 0
  - FSM in IDLE
  - synchronizer flops = 0
- Latency: `pbton` rises before edge 0, so `pb_s` is 1 after edge 1. The digits update on edge 1+DEB_CYCLES (edge 5 with defaults). `pressed` rises on the same edge.
- Auto-repeat, measured after the HELD entry edge E: increments occur at E+REPEAT_DELAY, then every REPEAT_PERIOD edges.
- Release: `pb_s` falls 2 edges after `pbton` falls. The FSM sees the low sample on the following edge, and that edge cannot increment.
- `wrap` is high for exactly one cycle and is aligned with the 000 digits.

## Configuration
- `PB_AUTOREPEAT_EN` defined: the REPEAT state, the hold timer, and the REPEAT_DELAY/REPEAT_PERIOD logic are present.
- `PB_AUTOREPEAT_EN` undefined: HELD only exits to DEB_REL, so exactly one increment occurs per accepted press. The REPEAT_* parameters remain declared but unused.

## Structure
- Package `pb_counter_pkg` contains:
  - enum `pb_state_t` (IDLE, DEB_PRESS, HELD, REPEAT, DEB_REL)
  - localparam `BCD_MAX` = 4'd9
- Sub-module `bcd_counter3` holds the three digit registers, the clr/increment/carry logic, and the `wrap` pulse.
- The top level holds the synchronizer, FSM, debounce counter and hold timer.

## Test plan
- Reset: assert RST mid-count → 000, `wrap`=0, `pressed`=0. After release, no increments until a debounced press.
- Clean press with defaults: `pbton` high for 10 cycles → `units`=1 on edge 5, `pressed`=1. Exactly one increment. `pressed`=0 after release debounce.
- Bounce: `pbton` pattern 1,1,0,1,1,0,1,0 (runs shorter than 4) → digits stay 000 and `pressed` stays 0.
- Auto-repeat (`PB_AUTOREPEAT_EN`): `pbton` high edges 0–29 → increments on edges 5, 21, 25, 29, final 004. The same stimulus without the macro → 001.
- Carry/wrap: hold with auto-repeat → 009→010, 099→100, 999→000 with `wrap`=1 for one cycle. No digit ever exceeds 9.
- `clr` asserted on the same edge as a pending increment at 999 → 000 with `wrap`=0. The next press → 001.

Source files
------------

// File: rtl/pb_counter_pkg.sv
// rtl/pb_counter_pkg.sv - shared types and constants for the debounced BCD push-button counter
package pb_counter_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DEB_PRESS = 3'd1,
        HELD      = 3'd2,
        REPEAT    = 3'd3,
        DEB_REL   = 3'd4
    } pb_state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_counter3.sv
// rtl/bcd_counter3.sv - three-digit BCD ripple counter with synchronous clear and rollover pulse
module bcd_counter3
    import pb_counter_pkg::*;
(
    input  logic       clkdiv0,
    input  logic       RST,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] units,
    output logic [3:0] tens,
    output logic [3:0] hundreds,
    output logic       wrap
);

    logic [3:0] units_q, units_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] hundreds_q, hundreds_d;
    logic       wrap_q, wrap_d;

    always_comb begin
        units_d    = units_q;
        tens_d     = tens_q;
        hundreds_d = hundreds_q;
        wrap_d     = 1'b0;
        if (clr) begin
            units_d    = 4'd0;
            tens_d     = 4'd0;
            hundreds_d = 4'd0;
        end else if (inc) begin
            if (units_q != BCD_MAX) begin
                units_d = units_q + 4'd1;
            end else begin
                units_d = 4'd0;
                if (tens_q != BCD_MAX) begin
                    tens_d = tens_q + 4'd1;
                end else begin
                    tens_d = 4'd0;
                    if (hundreds_q != BCD_MAX) begin
                        hundreds_d = hundreds_q + 4'd1;
                    end else begin
                        hundreds_d = 4'd0;
                        wrap_d     = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clkdiv0 or posedge RST) begin
        if (RST) begin
            units_q    <= 4'd0;
            tens_q     <= 4'd0;
            hundreds_q <= 4'd0;
            wrap_q     <= 1'b0;
        end else begin
            units_q    <= units_d;
            tens_q     <= tens_d;
            hundreds_q <= hundreds_d;
            wrap_q     <= wrap_d;
        end
    end

    assign units    = units_q;
    assign tens     = tens_q;
    assign hundreds = hundreds_q;
    assign wrap     = wrap_q;

endmodule

// File: rtl/pb_bcd_counter.sv
// rtl/pb_bcd_counter.sv - debounced push-button event counter with BCD digit outputs
// Optional auto-repeat while held is built when PB_AUTOREPEAT_EN is defined.
module pb_bcd_counter
    import pb_counter_pkg::*;
#(
    parameter int DEB_CYCLES    = 4,
    parameter int REPEAT_DELAY  = 16,
    parameter int REPEAT_PERIOD = 4
) (
    input  logic       clkdiv0,
    input  logic       RST,
    input  logic       pbton,
    input  logic       clr,
    output logic [3:0] units,
    output logic [3:0] tens,
    output logic [3:0] hundreds,
    output logic       wrap,
    output logic       pressed
);

    localparam int DW = $clog2(DEB_CYCLES + 1);

    if (DEB_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("pb_bcd_counter: DEB_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    logic            pb_meta_q, pb_s_q;
    pb_state_t       state_q, state_d;
    logic [DW-1:0]   deb_q, deb_d;
    logic            pressed_q, pressed_d;
    logic            inc;

`ifdef PB_AUTOREPEAT_EN
    localparam int HW = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
    logic [HW-1:0] hold_q, hold_d;
`endif

    always_comb begin
        state_d = state_q;
        deb_d   = deb_q;
        inc     = 1'b0;
`ifdef PB_AUTOREPEAT_EN
        hold_d  = hold_q;
`endif
        case (state_q)
            IDLE: begin
                if (pb_s_q) begin
                    if (DEB_CYCLES == 1) begin
                        inc     = 1'b1;
                        state_d = HELD;
`ifdef PB_AUTOREPEAT_EN
                        hold_d  = '0;
`endif
                    end else begin
                        state_d = DEB_PRESS;
                        deb_d   = DW'(1);
                    end
                end
            end
            DEB_PRESS: begin
                if (!pb_s_q) begin
                    state_d = IDLE;
                end else if (deb_q == DW'(DEB_CYCLES - 1)) begin
                    inc     = 1'b1;
                    state_d = HELD;
`ifdef PB_AUTOREPEAT_EN
                    hold_d  = '0;
`endif
                end else begin
                    deb_d = deb_q + DW'(1);
                end
            end
            HELD, REPEAT: begin
                if (!pb_s_q) begin
                    // The sample that leaves HELD is already the first low one of the release debounce.
                    state_d = (DEB_CYCLES == 1) ? IDLE : DEB_REL;
                    deb_d   = DW'(1);
                end
`ifdef PB_AUTOREPEAT_EN
                else if (state_q == HELD && hold_q == HW'(REPEAT_DELAY - 1)) begin
                    inc     = 1'b1;
                    state_d = REPEAT;
                    hold_d  = '0;
                end else if (state_q == REPEAT && hold_q == HW'(REPEAT_PERIOD - 1)) begin
                    inc    = 1'b1;
                    hold_d = '0;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
`endif
            end
            DEB_REL: begin
                if (pb_s_q) begin
                    state_d = HELD;
`ifdef PB_AUTOREPEAT_EN
                    hold_d  = '0;
`endif
                end else if (deb_q == DW'(DEB_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    deb_d = deb_q + DW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        pressed_d = (state_d == HELD) || (state_d == REPEAT) || (state_d == DEB_REL);
    end

    always_ff @(posedge clkdiv0 or posedge RST) begin
        if (RST) begin
            pb_meta_q <= 1'b0;
            pb_s_q    <= 1'b0;
            state_q   <= IDLE;
            deb_q     <= '0;
            pressed_q <= 1'b0;
        end else begin
            pb_meta_q <= pbton;
            pb_s_q    <= pb_meta_q;
            state_q   <= state_d;
            deb_q     <= deb_d;
            pressed_q <= pressed_d;
        end
    end

`ifdef PB_AUTOREPEAT_EN
    always_ff @(posedge clkdiv0 or posedge RST) begin
        if (RST) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`endif

    bcd_counter3 u_digits (
        .clkdiv0  (clkdiv0),
        .RST      (RST),
        .clr      (clr),
        .inc      (inc),
        .units    (units),
        .tens     (tens),
        .hundreds (hundreds),
        .wrap     (wrap)
    );

    assign pressed = pressed_q;

endmodule

// File: tb/tb_pb_bcd_counter.sv
// tb/tb_pb_bcd_counter.sv - directed self-checking bench for pb_bcd_counter
module tb_pb_bcd_counter;

`ifdef PB_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       clkdiv0;
    logic       RST;
    logic       pbton;
    logic       clr;
    logic [3:0] units, tens, hundreds;
    logic       wrap;
    logic       pressed;

    int n_tests = 0;
    int n_fail  = 0;
    int bad_digit = 0;

    pb_bcd_counter dut (
        .clkdiv0  (clkdiv0),
        .RST      (RST),
        .pbton    (pbton),
        .clr      (clr),
        .units    (units),
        .tens     (tens),
        .hundreds (hundreds),
        .wrap     (wrap),
        .pressed  (pressed)
    );

    initial clkdiv0 = 1'b0;
    always #5 clkdiv0 = ~clkdiv0;

    always @(negedge clkdiv0) begin
        if (units > 4'd9 || tens > 4'd9 || hundreds > 4'd9) bad_digit++;
    end

    task automatic tick();
        @(posedge clkdiv0);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] digits();
        return {20'd0, hundreds, tens, units};
    endfunction

    task automatic press(input int hi, input int lo);
        pbton = 1'b1;
        repeat (hi) tick();
        pbton = 1'b0;
        repeat (lo) tick();
    endtask

    logic seen_pressed;
    logic [7:0] bounce_pat;

    initial begin
        RST = 1'b1;
        pbton = 1'b0;
        clr = 1'b0;
        #1;
        check("reset_async_digits", digits(), 32'h000);
        repeat (3) tick();
        check("reset_digits", digits(), 32'h000);
        check("reset_wrap", {31'd0, wrap}, 32'd0);
        check("reset_pressed", {31'd0, pressed}, 32'd0);
        RST = 1'b0;
        repeat (6) tick();
        check("idle_no_count", digits(), 32'h000);

        // clean press: pbton high for edges 0..9
        pbton = 1'b1;
        repeat (5) tick();
        check("latency_edge4_digits", digits(), 32'h000);
        check("latency_edge4_pressed", {31'd0, pressed}, 32'd0);
        tick();
        check("latency_edge5_digits", digits(), 32'h001);
        check("latency_edge5_pressed", {31'd0, pressed}, 32'd1);
        repeat (4) tick();
        pbton = 1'b0;
        repeat (5) tick();
        check("release_edge14_pressed", {31'd0, pressed}, 32'd1);
        check("single_increment", digits(), 32'h001);
        tick();
        check("release_edge15_pressed", {31'd0, pressed}, 32'd0);

        // bounce: no run of highs reaches the debounce length
        bounce_pat = 8'b0101_1011;
        seen_pressed = 1'b0;
        for (int i = 0; i < 8; i++) begin
            pbton = bounce_pat[i];
            tick();
            seen_pressed |= pressed;
        end
        pbton = 1'b0;
        repeat (8) begin
            tick();
            seen_pressed |= pressed;
        end
        check("bounce_digits", digits(), 32'h001);
        check("bounce_pressed", {31'd0, seen_pressed}, 32'd0);

        // reset while held, button still held at release
        pbton = 1'b1;
        repeat (6) tick();
        check("pre_reset_count", digits(), 32'h002);
        RST = 1'b1;
        #1;
        check("midrst_digits", digits(), 32'h000);
        check("midrst_pressed", {31'd0, pressed}, 32'd0);
        check("midrst_wrap", {31'd0, wrap}, 32'd0);
        repeat (2) tick();
        RST = 1'b0;
        repeat (5) tick();
        check("postrst_edge4", digits(), 32'h000);
        tick();
        check("postrst_edge5", digits(), 32'h001);
        check("postrst_pressed", {31'd0, pressed}, 32'd1);
        repeat (4) tick();
        pbton = 1'b0;
        repeat (8) tick();
        check("postrst_one_inc", digits(), 32'h001);
        check("postrst_released", {31'd0, pressed}, 32'd0);

        // long hold: edges 0..29
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_digits", digits(), 32'h000);
        pbton = 1'b1;
        repeat (21) tick();
        check("hold_edge20", digits(), 32'h001);
        tick();
        check("hold_edge21", digits(), AR ? 32'h002 : 32'h001);
        repeat (8) tick();
        pbton = 1'b0;
        repeat (10) tick();
        check("hold_final", digits(), AR ? 32'h004 : 32'h001);
        check("hold_released", {31'd0, pressed}, 32'd0);

        // carries through individual presses
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (9) press(5, 7);
        check("count_009", digits(), 32'h009);
        press(5, 7);
        check("carry_010", digits(), 32'h010);
        repeat (89) press(5, 7);
        check("count_099", digits(), 32'h099);
        press(5, 7);
        check("carry_100", digits(), 32'h100);
        repeat (899) press(5, 7);
        check("count_999", digits(), 32'h999);

        // clr on the same edge as the pending 999 increment
        pbton = 1'b1;
        repeat (5) tick();
        check("clr_pre_999", digits(), 32'h999);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_priority_digits", digits(), 32'h000);
        check("clr_priority_wrap", {31'd0, wrap}, 32'd0);
        tick();
        check("clr_priority_wrap_next", {31'd0, wrap}, 32'd0);
        pbton = 1'b0;
        repeat (8) tick();
        press(5, 7);
        check("after_clr_press", digits(), 32'h001);

        // 999 -> 000 rollover
        repeat (998) press(5, 7);
        check("count_999_again", digits(), 32'h999);
        pbton = 1'b1;
        repeat (5) tick();
        check("wrap_before", {20'd0, hundreds, tens, units} | {31'd0, wrap} << 16, 32'h999);
        tick();
        check("wrap_digits", digits(), 32'h000);
        check("wrap_pulse", {31'd0, wrap}, 32'd1);
        tick();
        check("wrap_one_cycle", {31'd0, wrap}, 32'd0);
        pbton = 1'b0;
        repeat (8) tick();
        check("wrap_settled", digits(), 32'h000);
        check("digit_range", bad_digit, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
